// File: rtl/skew_feeder_int8.sv
// -----------------------------------------------------------------------------
// skew_feeder_int8
//
// Buffers int8 vectors in a small FIFO and feeds them into per-lane
// shift-register chains with a diagonal skew: element i of each vector is
// presented on lane i, i cycles after lane 0. This is the wavefront shape a
// systolic array expects on its edge.
//
// A vector accepted into an empty FIFO from IDLE reaches lane 0 two edges
// later: one edge for IDLE->RUN and one edge for the pop into the lane-0
// stage.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-low reset
//   in_valid   upstream presents a vector on in_data
//   in_data    LANES x int8, element i at [8i+7:8i]
//   in_ready   FIFO has room (registered occupancy < DEPTH) and not in reset
//   lane_load  per-lane load strobe
//   lane_data  per-lane byte, lane i at [8i+7:8i], 8'h00 when lane is idle
//   busy       FSM is not IDLE
//   vec_count  (SKEW_FEEDER_STATS_EN only) saturating 16-bit pop counter
//
// Configuration macro: SKEW_FEEDER_STATS_EN adds the vec_count output.
// -----------------------------------------------------------------------------
module skew_feeder_int8 #(
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [LANES*8-1:0] in_data,
    output logic               in_ready,
    output logic [LANES-1:0]   lane_load,
    output logic [LANES*8-1:0] lane_data,
    output logic               busy
`ifdef SKEW_FEEDER_STATS_EN
    ,
    output logic [15:0]        vec_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      drain_q, drain_d;

    logic [LANES*8-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        occ_q;
    logic [LANES*8-1:0] head;
    logic               push, pop;

    // Ready is gated by reset so nothing is offered while the block is held.
    assign in_ready = reset && (occ_q < (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q != IDLE) && (occ_q != '0);
    assign busy     = (state_q != IDLE);
    assign head     = mem[rd_ptr_q];

    // ------------------------------------------------------------------ FIFO
    // NOTE: the payload array has no reset; occupancy and pointers alone say
    // which entries are live, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (occ_q != '0) state_d = RUN;
            end
            RUN: begin
                // FIFO ran dry: wait LANES-1 more edges for the deepest lane.
                if (!pop) begin
                    state_d = DRAIN;
                    drain_d = CW'(LANES - 1);
                end
            end
            DRAIN: begin
                // A new vector resumes streaming; skew stages keep their data.
                if (pop) begin
                    state_d = RUN;
                end else if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------ skew chains
    // Lane g owns g+1 stages: stage 0 loads on pop, the rest add one cycle
    // each. Idle slots shift zeros so bubbles present 8'h00.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [g:0] vld_q;
        logic [7:0] dat_q [0:g];

        always_ff @(posedge clk) begin
            if (!reset) begin
                vld_q <= '0;
                for (int j = 0; j <= g; j++) dat_q[j] <= 8'h00;
            end else begin
                vld_q[0] <= pop;
                dat_q[0] <= pop ? head[8*g +: 8] : 8'h00;
                for (int j = 1; j <= g; j++) begin
                    vld_q[j] <= vld_q[j-1];
                    dat_q[j] <= dat_q[j-1];
                end
            end
        end

        assign lane_load[g]        = vld_q[g];
        assign lane_data[8*g +: 8] = dat_q[g];
    end

`ifdef SKEW_FEEDER_STATS_EN
    // ---------------------------------------------------------- pop counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            vec_count <= '0;
        end else if (pop && (vec_count != 16'hFFFF)) begin
            vec_count <= vec_count + 16'd1;
        end
    end
`endif

endmodule
